// File: rtl/st_h2c_checker.sv
// AXI-Stream H2C sink: forwards beats downstream and checks an incrementing lane pattern.
// Define H2C_ERR_CAPTURE_EN to implement the err_qid/err_beat capture registers.
module st_h2c_checker #(
    parameter int BIT_WIDTH  = 64,
    parameter int PATT_WIDTH = 16,
    parameter int QID_WIDTH  = 11,
    localparam int BYTES     = BIT_WIDTH / 8,
    localparam int LANES     = BIT_WIDTH / PATT_WIDTH,
    localparam int MTY_W     = $clog2(BIT_WIDTH / 8)
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    input  logic [31:0]          control_reg,
    input  logic                 clr_match,
    input  logic [BIT_WIDTH-1:0] h2c_tdata,
    input  logic                 h2c_tvalid,
    input  logic                 h2c_tlast,
    input  logic [QID_WIDTH-1:0] h2c_tuser_qid,
    input  logic [MTY_W-1:0]     h2c_tuser_mty,
    input  logic                 h2c_tuser_zero_byte,
    output logic                 h2c_tready,
    input  logic                 inbusy,
    output logic                 we,
    output logic [BIT_WIDTH-1:0] din,
    output logic                 h2c_match,
    output logic                 h2c_fail,
    output logic [31:0]          h2c_pkt_count,
    output logic [31:0]          h2c_beat_count,
    output logic [31:0]          h2c_byte_count,
    output logic [QID_WIDTH-1:0] err_qid,
    output logic [15:0]          err_beat
);

    typedef enum logic [1:0] {StIdle, StPkt, StHalt} state_e;

    state_e                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [15:0]            beat_idx_q, beat_idx_d;
    logic                   fail_q, fail_d;
    logic                   match_q, match_d;
    logic [31:0]            pkt_q, pkt_d;
    logic [31:0]            beat_q, beat_d;
    logic [31:0]            byte_q, byte_d;

    logic                   loopback;
    logic                   throttle;
    logic                   accept;
    logic                   live;
    logic                   zero_beat;
    logic                   bad;
    logic                   mismatch;
    logic [31:0]            valid_bytes;
    logic [31:0]            byte_inc;
    logic [BIT_WIDTH-1:0]   exp_data;
    logic                   unused_ctrl;

    assign unused_ctrl = ^control_reg[31:3];

    assign loopback   = control_reg[0];
    assign throttle   = control_reg[1] & lfsr_q[0];
    assign h2c_tready = inbusy & ~throttle & (state_q != StHalt);
    assign accept     = h2c_tvalid & h2c_tready;
    // A beat taken during clr_match is forwarded but otherwise invisible.
    assign live       = accept & ~clr_match;
    assign zero_beat  = h2c_tlast & h2c_tuser_zero_byte;
    assign we         = accept;
    assign din        = h2c_tdata;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_comb begin
        exp_data    = '0;
        bad         = 1'b0;
        valid_bytes = h2c_tlast ? (32'(BYTES) - 32'(h2c_tuser_mty)) : 32'(BYTES);
        for (int j = 0; j < LANES; j++) begin
            exp_data[j*PATT_WIDTH +: PATT_WIDTH] =
                PATT_WIDTH'(32'(beat_idx_q) * 32'(LANES) + 32'(j));
        end
        for (int b = 0; b < BYTES; b++) begin
            if ((32'(b) < valid_bytes) && (h2c_tdata[b*8 +: 8] != exp_data[b*8 +: 8])) begin
                bad = 1'b1;
            end
        end
    end

    assign mismatch = live & ~loopback & ~zero_beat & bad;
    assign byte_inc = zero_beat ? 32'd0 : valid_bytes;

    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        fail_d     = fail_q;
        match_d    = match_q;
        pkt_d      = pkt_q;
        beat_d     = beat_q;
        byte_d     = byte_q;
        if (clr_match) begin
            state_d    = StIdle;
            beat_idx_d = '0;
            fail_d     = 1'b0;
            match_d    = 1'b0;
            pkt_d      = '0;
            beat_d     = '0;
            byte_d     = '0;
        end else begin
            if (live) begin
                beat_d     = beat_q + 32'd1;
                byte_d     = byte_q + byte_inc;
                beat_idx_d = h2c_tlast ? 16'd0 : beat_idx_q + 16'd1;
                if (h2c_tlast) begin
                    pkt_d = pkt_q + 32'd1;
                end
            end
            if (mismatch) begin
                fail_d = 1'b1;
            end
            if (fail_q || mismatch) begin
                match_d = 1'b0;
            end else if (live && h2c_tlast && !loopback) begin
                match_d = 1'b1;
            end
            unique case (state_q)
                StIdle:  if (live && !h2c_tlast) state_d = StPkt;
                StPkt:   if (live && h2c_tlast)  state_d = StIdle;
                StHalt:  state_d = StHalt;
                default: state_d = StIdle;
            endcase
            if (mismatch && control_reg[2]) begin
                state_d = StHalt;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q    <= StIdle;
            lfsr_q     <= 16'hACE1;
            beat_idx_q <= '0;
            fail_q     <= 1'b0;
            match_q    <= 1'b0;
            pkt_q      <= '0;
            beat_q     <= '0;
            byte_q     <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            beat_idx_q <= beat_idx_d;
            fail_q     <= fail_d;
            match_q    <= match_d;
            pkt_q      <= pkt_d;
            beat_q     <= beat_d;
            byte_q     <= byte_d;
        end
    end

    assign h2c_match      = match_q & ~fail_q & ~loopback;
    assign h2c_fail       = fail_q;
    assign h2c_pkt_count  = pkt_q;
    assign h2c_beat_count = beat_q;
    assign h2c_byte_count = byte_q;

`ifdef H2C_ERR_CAPTURE_EN
    logic [QID_WIDTH-1:0] err_qid_q, err_qid_d;
    logic [15:0]          err_beat_q, err_beat_d;

    // Only the first mismatch since the last clear is recorded.
    always_comb begin
        err_qid_d  = err_qid_q;
        err_beat_d = err_beat_q;
        if (clr_match) begin
            err_qid_d  = '0;
            err_beat_d = '0;
        end else if (mismatch && !fail_q) begin
            err_qid_d  = h2c_tuser_qid;
            err_beat_d = beat_idx_q;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            err_qid_q  <= '0;
            err_beat_q <= '0;
        end else begin
            err_qid_q  <= err_qid_d;
            err_beat_q <= err_beat_d;
        end
    end

    assign err_qid  = err_qid_q;
    assign err_beat = err_beat_q;
`else
    logic unused_qid;
    assign unused_qid = ^h2c_tuser_qid;
    assign err_qid    = '0;
    assign err_beat   = '0;
`endif

endmodule

// File: tb/tb_st_h2c_checker.sv
// Directed self-checking bench for st_h2c_checker at BIT_WIDTH=64, PATT_WIDTH=16.
module tb_st_h2c_checker;

`ifdef H2C_ERR_CAPTURE_EN
    localparam logic [10:0] ExpErrQid  = 11'd5;
    localparam logic [15:0] ExpErrBeat = 16'd1;
`else
    localparam logic [10:0] ExpErrQid  = 11'd0;
    localparam logic [15:0] ExpErrBeat = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ctrl;
    logic        clr;
    logic [63:0] tdata;
    logic        tvalid, tlast, zb, tready, inbusy, we, match, fail;
    logic [10:0] qid, eq;
    logic [2:0]  mty;
    logic [63:0] din;
    logic [31:0] pkt, bcnt, bytc;
    logic [15:0] eb;

    int          checks = 0;
    int          passes = 0;
    int          we_cnt = 0;
    int          w, w0, k, cyc, tmis, derr;
    logic [63:0] dq[$];
    logic [15:0] mlfsr;

    always #5 clk = ~clk;

    st_h2c_checker #(.BIT_WIDTH(64), .PATT_WIDTH(16), .QID_WIDTH(11)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n), .control_reg(ctrl), .clr_match(clr),
        .h2c_tdata(tdata), .h2c_tvalid(tvalid), .h2c_tlast(tlast), .h2c_tuser_qid(qid),
        .h2c_tuser_mty(mty), .h2c_tuser_zero_byte(zb), .h2c_tready(tready), .inbusy(inbusy),
        .we(we), .din(din), .h2c_match(match), .h2c_fail(fail), .h2c_pkt_count(pkt),
        .h2c_beat_count(bcnt), .h2c_byte_count(bytc), .err_qid(eq), .err_beat(eb)
    );

    // Reference for x^16+x^14+x^13+x^11+1, right-shifting, seed ACE1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mlfsr <= 16'hACE1;
        else        mlfsr <= {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
    end

    always @(posedge clk) begin
        if (we) begin
            we_cnt++;
            dq.push_back(din);
        end
    end

    function automatic logic [63:0] pat(input int idx);
        logic [63:0] r;
        for (int j = 0; j < 4; j++) r[j*16 +: 16] = 16'(idx * 4 + j);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send(input logic [63:0] d, input bit last, input logic [2:0] m, input bit z,
                        input logic [10:0] q, output int waits);
        tdata = d; tlast = last; mty = m; zb = z; qid = q; tvalid = 1'b1; waits = 0;
        #1;
        while (!tready && waits < 100) begin
            @(negedge clk); #1; waits++;
        end
        if (!tready) chk("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; zb = 1'b0; mty = 3'd0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ctrl = 32'd2; clr = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        zb = 1'b0; qid = '0; mty = '0; inbusy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_pkt", pkt, 0);
        chk("rst_beat", bcnt, 0);
        chk("rst_byte", bytc, 0);
        chk("rst_match", match, 0);
        chk("rst_fail", fail, 0);
        chk("rst_errq", eq, 0);
        chk("rst_errb", eb, 0);
        chk("rst_we", we, 0);
        chk("rst_seed_throttle", tready, 0);
        @(negedge clk); #1;
        chk("lfsr_step1_ready", tready, 1);
        ctrl = 32'd0;
        @(negedge clk);

        // Single 4-beat packet
        w0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            send(pat(i), i == 3, 3'd0, 1'b0, 11'd1, w);
            chk("t1_no_wait", w, 0);
        end
        #1;
        chk("t1_pkt", pkt, 1);
        chk("t1_beat", bcnt, 4);
        chk("t1_byte", bytc, 32);
        chk("t1_match", match, 1);
        chk("t1_fail", fail, 0);
        chk("t1_we_pulses", we_cnt - w0, 4);
        @(negedge clk);

        // Two 3-beat packets, second ends with mty=6 and garbage above byte 1
        pulse_clr();
        chk("clr_beat", bcnt, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) send(pat(i), i == 2, 3'd0, 1'b0, 11'd2, w);
        send(pat(0), 1'b0, 3'd0, 1'b0, 11'd2, w);
        send(pat(1), 1'b0, 3'd0, 1'b0, 11'd2, w);
        send({48'hDEAD_BEEF_CAFE, 16'd8}, 1'b1, 3'd6, 1'b0, 11'd2, w);
        #1;
        chk("t2_match", match, 1);
        chk("t2_fail", fail, 0);
        chk("t2_pkt", pkt, 2);
        chk("t2_beat", bcnt, 6);
        chk("t2_byte", bytc, 42);
        @(negedge clk);

        // Lane 2 of beat 1 corrupted on qid 5
        pulse_clr();
        @(negedge clk);
        send(pat(0), 1'b0, 3'd0, 1'b0, 11'd5, w);
        send(pat(1) ^ 64'h0000_0001_0000_0000, 1'b0, 3'd0, 1'b0, 11'd5, w);
        #1;
        chk("t3_fail_early", fail, 1);
        @(negedge clk);
        send(pat(2), 1'b1, 3'd0, 1'b0, 11'd5, w);
        #1;
        chk("t3_fail", fail, 1);
        chk("t3_match", match, 0);
        chk("t3_errq", eq, ExpErrQid);
        chk("t3_errb", eb, ExpErrBeat);
        @(negedge clk);
        send(pat(0) ^ 64'hFF, 1'b1, 3'd0, 1'b0, 11'd7, w);
        #1;
        chk("t3_errq_kept", eq, ExpErrQid);
        chk("t3_errb_kept", eb, ExpErrBeat);
        chk("t3_match2", match, 0);
        @(negedge clk);

        // Stop-on-error halts the stream until clr_match
        pulse_clr();
        chk("clr_fail", fail, 0);
        chk("clr_errq", eq, 0);
        ctrl = 32'd4;
        @(negedge clk);
        send(pat(0), 1'b0, 3'd0, 1'b0, 11'd2, w);
        send(pat(1) ^ 64'h1, 1'b0, 3'd0, 1'b0, 11'd2, w);
        tdata = pat(2); tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_halt_ready", tready, 0);
            chk("t4_halt_we", we, 0);
            @(negedge clk);
        end
        chk("t4_halt_beat", bcnt, 2);
        chk("t4_halt_fail", fail, 1);
        tvalid = 1'b0;
        pulse_clr();
        chk("t4_clr_beat", bcnt, 0);
        chk("t4_clr_pkt", pkt, 0);
        chk("t4_clr_fail", fail, 0);
        chk("t4_clr_ready", tready, 1);
        @(negedge clk);

        // LFSR back-pressure over a 100-beat packet
        ctrl = 32'd2;
        pulse_clr();
        @(negedge clk);
        dq.delete();
        k = 0; cyc = 0; tmis = 0;
        while (k < 100 && cyc < 1000) begin
            tdata = pat(k); tlast = (k == 99); tvalid = 1'b1;
            #1;
            if (tready !== ~mlfsr[0]) tmis++;
            if (tready) k++;
            @(negedge clk);
            cyc++;
        end
        tvalid = 1'b0; tlast = 1'b0;
        #1;
        chk("t5_all_sent", k, 100);
        chk("t5_ready_vs_lfsr", tmis, 0);
        chk("t5_throttled", cyc > 100, 1);
        chk("t5_beat", bcnt, 100);
        chk("t5_pkt", pkt, 1);
        chk("t5_match", match, 1);
        derr = 0;
        foreach (dq[i]) if (dq[i] !== pat(i)) derr++;
        chk("t5_din_count", dq.size(), 100);
        chk("t5_din_errs", derr, 0);
        ctrl = 32'd0;
        @(negedge clk);

        // Beat during clr_match is forwarded, not counted or checked
        clr = 1'b1; tdata = 64'h1234_5678_9ABC_DEF0; tvalid = 1'b1;
        #1;
        chk("t6_clr_we", we, 1);
        @(negedge clk);
        clr = 1'b0; tvalid = 1'b0;
        #1;
        chk("t6_clr_beat", bcnt, 0);
        chk("t6_clr_fail", fail, 0);
        @(negedge clk);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0, 1'b1, 11'd3, w);
        #1;
        chk("t6_zb_pkt", pkt, 1);
        chk("t6_zb_byte", bytc, 0);
        chk("t6_zb_beat", bcnt, 1);
        chk("t6_zb_fail", fail, 0);
        chk("t6_zb_match", match, 1);
        ctrl = 32'd1;
        @(negedge clk);
        send(64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 3'd0, 1'b0, 11'd3, w);
        send(64'hBAD1_BAD1_BAD1_BAD1, 1'b1, 3'd0, 1'b0, 11'd3, w);
        #1;
        chk("t6_lb_pkt", pkt, 2);
        chk("t6_lb_beat", bcnt, 3);
        chk("t6_lb_byte", bytc, 16);
        chk("t6_lb_fail", fail, 0);
        chk("t6_lb_match", match, 0);
        ctrl = 32'd0;
        @(negedge clk);

        // Asynchronous reset mid-packet; next beat is SOP again
        send(pat(0), 1'b0, 3'd0, 1'b0, 11'd9, w);
        tdata = pat(1); tvalid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_beat", bcnt, 0);
        chk("t7_rst_pkt", pkt, 0);
        chk("t7_rst_byte", bytc, 0);
        chk("t7_rst_match", match, 0);
        tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(pat(0), 1'b1, 3'd0, 1'b0, 11'd9, w);
        #1;
        chk("t7_sop_match", match, 1);
        chk("t7_sop_fail", fail, 0);
        chk("t7_sop_beat", bcnt, 1);
        chk("t7_sop_byte", bytc, 8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
